gpio_video_tx: RTL and testbench
================================

// Module: gpio_video_tx
// PURPOSE
//  Transmit side of the 3-bit GPIO video link (data R/G/B, active-low hsync/vsync).
//  Pulls pixels from an upstream source over a valid/ready stream and serialises a
//  256x256 raster with blanking and sync onto GPIO outputs. It drives a second board's
//  sampling display, which refreshes when hsync and vsync are low together.
// PARAMETERS
//  H_ACTIVE  256  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    32   hsync pulse width, in pixels
//  H_BP      16   horizontal back porch, in pixels
//  V_ACTIVE  256  visible lines per frame
//  V_FP      4    vertical front porch, in lines
//  V_SYNC    4    vsync pulse width, in lines
//  V_BP      8    vertical back porch, in lines
//  PIX_DIV   2    clocks per pixel; minimum 1
// PORTS
//  clock       in   1   system clock
//  reset_n     in   1   asynchronous, active-low reset
//  enable      in   1   start and continue frames
//  pix_data    in   3   {B,G,R} pixel from upstream
//  pix_valid   in   1   pix_data is valid
//  pix_ready   out  1   pixel accepted this cycle when pix_valid=1
//  tx_data     out  3   GPIO pixel bits; 0 outside the active area
//  tx_hsync_n  out  1   horizontal sync, active low
//  tx_vsync_n  out  1   vertical sync, active low
//  frame_start out  1   1-cycle pulse at the first active pixel of a frame
//  underflow   out  1   sticky: an active pixel went out with no valid input
//  busy        out  1   a frame is in progress
// BEHAVIOUR
//  - Reset: all outputs go to their idle values and the FSM goes to IDLE.
//    Idle values: tx_data=0, tx_hsync_n=1, tx_vsync_n=1, pix_ready=0, frame_start=0,
//    underflow=0, busy=0. Reset asserted mid-frame aborts the frame at once; no partial line.
//  - Pixel tick: a divider counts 0..PIX_DIV-1; tick=1 when the count is 0.
//    The divider is held at 0 while in IDLE.
//  - Horizontal FSM per line: ACTIVE(H_ACTIVE) -> FP(H_FP) -> SYNC(H_SYNC) -> BP(H_BP)
//    -> ACTIVE. Each state lasts its count of ticks. Line period = 320 ticks (defaults).
//  - Vertical counter: advances at the end of BP. Rows 0..V_ACTIVE-1 are active, then
//    V_FP, V_SYNC and V_BP lines, then it wraps to 0. Frame = 272 lines (defaults).
//  - tx_hsync_n=0 during SYNC on every line, including vertical blanking lines.
//  - tx_vsync_n=0 for all ticks of the V_SYNC lines, so hsync and vsync overlap.
//  - Outside the active area (horizontal or vertical), tx_data=0 and pix_ready=0.
//  - pix_ready=1 only on a tick within an active pixel of an active row, and never in
//    any other cycle. A transfer happens when pix_valid and pix_ready are both 1.
//  - Latency: a transfer in cycle N appears on tx_data in cycle N+1, together with the
//    sync levels for that pixel. All outputs are registered and mutually aligned.
//    tx_data holds its value for PIX_DIV clocks.
//  - Underflow: if an active tick arrives with pix_valid=0, tx_data=0 for that pixel
//    and underflow is set. It stays set until reset; there is no retry or stall.
//  - Start: from IDLE with enable=1, the first tick is row 0, pixel 0.
//    frame_start pulses together with that pixel on tx_data (cycle N+1).
//    busy=1 from that point.
//  - Stop: enable=0 mid-frame finishes the current frame. After the last V_BP line the
//    FSM goes to IDLE. With enable still 1, the next frame starts back-to-back.
//  - Counter widths: ceil(log2(line or frame total)). Wrap is explicit, never by overflow.
// CONFIGURATION
//  - GPIO_TX_TEST_PATTERN_EN defined: adds input port test_pattern (1 bit).
//    - While test_pattern=1: pix_ready is held 0, tx_data = col[7:5] in active areas
//      (8 colour bars), and underflow is not updated.
//    - test_pattern is sampled only at the start of a line.
//  - Macro undefined: the test_pattern port and its logic are absent; stream only.
// STRUCTURE
//  - Package gpio_video_pkg holds:
//    - the h-state enum {H_ACTIVE_S, H_FP_S, H_SYNC_S, H_BP_S} and the IDLE state;
//    - the default timing constants;
//    - the link bit order {B,G,R} = {gpio14,gpio4,gpio0}.
//  - One sub-module, gpio_video_timing, contains the tick divider, h-FSM and v-counter.
//    Outputs: col, row, active, hsync, vsync, tick.
//    The top level adds the handshake, output registers, underflow and test pattern.
// TESTING
//  - Reset mid-frame at row 10 col 100 -> next cycle: tx_hsync_n=1, tx_vsync_n=1,
//    tx_data=0, busy=0, underflow=0.
//  - PIX_DIV=1, pix_valid always 1, pixel = col[2:0]:
//    - pix_ready high for 256 cycles per active line;
//    - tx_hsync_n low for 32 cycles, starting 272 cycles after the line start;
//    - line period 320 cycles.
//  - Full frame, defaults:
//    - tx_vsync_n low from line 260 to line 263 inclusive (1280 ticks);
//    - hsync pulses continue during vsync;
//    - frame_start once per 272 lines.
//  - pix_valid dropped for pixel 5 of row 3 -> that pixel's tx_data=0, underflow=1 and
//    it stays 1; the remaining pixels are undisturbed.
//  - enable dropped at row 100 -> the frame finishes to line 271, then busy=0 and the
//    outputs are idle.
//  - With GPIO_TX_TEST_PATTERN_EN and test_pattern=1 -> col 0..31 give tx_data=0,
//    col 224..255 give 7, pix_ready stays 0, and underflow stays 0.

Source files
------------

// File: rtl/gpio_video_pkg.sv
// Shared definitions for the GPIO video transmit path.
// Holds the horizontal state encoding (including IDLE), the default raster timing
// and the physical link bit order {B,G,R} = {gpio14,gpio4,gpio0}.
package gpio_video_pkg;

  typedef enum logic [2:0] {
    H_ACTIVE_S,
    H_FP_S,
    H_SYNC_S,
    H_BP_S,
    IDLE_S
  } h_state_e;

  // Default 256x256 raster timing
  localparam int unsigned H_ACTIVE_DEF = 256;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 32;
  localparam int unsigned H_BP_DEF     = 16;
  localparam int unsigned V_ACTIVE_DEF = 256;
  localparam int unsigned V_FP_DEF     = 4;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BP_DEF     = 8;
  localparam int unsigned PIX_DIV_DEF  = 2;

  // Bit positions inside pix_data / tx_data
  localparam int unsigned LINK_R_BIT = 0;
  localparam int unsigned LINK_G_BIT = 1;
  localparam int unsigned LINK_B_BIT = 2;

  // Board GPIO pins that carry each colour bit
  localparam int unsigned GPIO_R_PIN = 0;
  localparam int unsigned GPIO_G_PIN = 4;
  localparam int unsigned GPIO_B_PIN = 14;

  // Counter width helper; never returns 0 so a divide-by-1 still gets a 1-bit register
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/gpio_video_timing.sv
// Raster timing generator: pixel-tick divider, horizontal FSM and vertical line counter.
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   enable          start a frame from IDLE / chain the next frame at end of frame
//   col             position within the line (0..H_TOTAL-1)
//   row             line within the frame (0..V_TOTAL-1)
//   active          current position is a visible pixel of a visible row
//   hsync, vsync    active-high sync levels for the current position
//   tick            one clock per pixel; qualifies all positional outputs
//   running         a frame is being scanned (FSM not in IDLE)
module gpio_video_timing
  import gpio_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = clog2_min1(H_TOTAL),
  localparam int unsigned VW      = clog2_min1(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic [HW-1:0] col,
  output logic [VW-1:0] row,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          tick,
  output logic          running
);

  localparam int unsigned DW = clog2_min1(PIX_DIV);

  localparam logic [DW-1:0] DIV_LAST     = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FP_LAST    = HW'(H_ACTIVE + H_FP - 1);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  h_state_e      state_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] col_q;
  logic [VW-1:0] row_q;

  assign running = (state_q != IDLE_S);
  assign tick    = running && (div_q == '0);
  assign col     = col_q;
  assign row     = row_q;
  assign active  = (state_q == H_ACTIVE_S) && (row_q < V_ACT_END);
  assign hsync   = (state_q == H_SYNC_S);
  assign vsync   = running && (row_q >= V_SYNC_FIRST) && (row_q < V_SYNC_END);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_S;
      div_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else if (state_q == IDLE_S) begin
      // Counters parked at row 0 / pixel 0 so the first tick after start is that pixel
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
      if (enable) state_q <= H_ACTIVE_S;
    end else begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (tick) begin
        col_q <= (col_q == H_LAST) ? '0 : col_q + 1'b1;
        case (state_q)
          H_ACTIVE_S: if (col_q == H_ACT_LAST) state_q <= H_FP_S;
          H_FP_S:     if (col_q == H_FP_LAST) state_q <= H_SYNC_S;
          H_SYNC_S:   if (col_q == H_SYNC_LAST) state_q <= H_BP_S;
          H_BP_S: begin
            if (col_q == H_LAST) begin
              if (row_q == V_LAST) begin
                row_q   <= '0;
                // Back-to-back frames while enabled; otherwise stop cleanly at frame end
                state_q <= enable ? H_ACTIVE_S : IDLE_S;
              end else begin
                row_q   <= row_q + 1'b1;
                state_q <= H_ACTIVE_S;
              end
            end
          end
          default: state_q <= IDLE_S;
        endcase
      end
    end
  end

endmodule

// File: rtl/gpio_video_tx.sv
// Transmit side of the 3-bit GPIO video link.
// Pulls {B,G,R} pixels over a valid/ready stream and serialises a raster with blanking
// and active-low syncs. All pixel-side outputs are registered and mutually aligned,
// one clock after the pixel is accepted.
// Optional feature: define GPIO_TX_TEST_PATTERN_EN to add the test_pattern input
// (8 colour bars from col[7:5], stream input ignored, sampled at each line start).
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   enable           start and continue frames
//   test_pattern     (GPIO_TX_TEST_PATTERN_EN only) colour-bar mode for the line
//   pix_data         {B,G,R} pixel from upstream
//   pix_valid        pix_data is valid
//   pix_ready        pixel accepted this cycle when pix_valid=1
//   tx_data          GPIO pixel bits, 0 outside the active area
//   tx_hsync_n       horizontal sync, active low
//   tx_vsync_n       vertical sync, active low
//   frame_start      1-cycle pulse with the first active pixel of a frame
//   underflow        sticky: an active pixel went out with no valid input
//   busy             a frame is in progress
module gpio_video_tx
  import gpio_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = clog2_min1(H_TOTAL),
  localparam int unsigned VW      = clog2_min1(V_TOTAL)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
`ifdef GPIO_TX_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  input  logic [2:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [2:0] tx_data,
  output logic       tx_hsync_n,
  output logic       tx_vsync_n,
  output logic       frame_start,
  output logic       underflow,
  output logic       busy
);

  logic [HW-1:0] col;
  logic [VW-1:0] row;
  logic          active;
  logic          hsync;
  logic          vsync;
  logic          tick;
  logic          running;

  gpio_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .col     (col),
    .row     (row),
    .active  (active),
    .hsync   (hsync),
    .vsync   (vsync),
    .tick    (tick),
    .running (running)
  );

  logic line_start;
  logic tp_line;
  logic pix_tick;

  assign line_start = tick && (col == '0);

`ifdef GPIO_TX_TEST_PATTERN_EN
  logic tp_line_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tp_line_q <= 1'b0;
    end else if (line_start) begin
      tp_line_q <= test_pattern;
    end
  end

  // Pixel 0 of a line uses the live input; the rest of the line uses the sampled copy
  assign tp_line = line_start ? test_pattern : tp_line_q;
`else
  assign tp_line = 1'b0;
`endif

  assign pix_tick  = tick && active;
  assign pix_ready = pix_tick && !tp_line;

  logic [2:0] data_d;

  always_comb begin
    data_d = '0;
    if (pix_tick) begin
      if (tp_line) begin
        data_d = col[7:5];
      end else if (pix_valid) begin
        data_d = pix_data;
      end
    end
  end

  logic [2:0] tx_data_q;
  logic       hsync_n_q;
  logic       vsync_n_q;
  logic       frame_start_q;
  logic       underflow_q;
  logic       busy_q;

  // Outputs only change on ticks, so each pixel holds for PIX_DIV clocks and the
  // blanking values of the last BP pixel are what remains visible in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q     <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (!running) busy_q <= 1'b0;
      if (tick) begin
        tx_data_q     <= data_d;
        hsync_n_q     <= !hsync;
        vsync_n_q     <= !vsync;
        frame_start_q <= pix_tick && (col == '0) && (row == '0);
        busy_q        <= 1'b1;
        if (pix_tick && !tp_line && !pix_valid) underflow_q <= 1'b1;
      end
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_hsync_n  = hsync_n_q;
  assign tx_vsync_n  = vsync_n_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gpio_video_tx.sv
// Directed bench for gpio_video_tx with PIX_DIV=1 and default raster timing.
module tb_gpio_video_tx;

  localparam int LINE  = 320;
  localparam int FRAME = 320 * 272;
  localparam int DROP  = 3 * LINE + 5;   // row 3, pixel 5
  localparam int STOP  = 100 * LINE;     // enable dropped at row 100

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [2:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] tx_data;
  logic       tx_hsync_n;
  logic       tx_vsync_n;
  logic       frame_start;
  logic       underflow;
  logic       busy;
`ifdef GPIO_TX_TEST_PATTERN_EN
  logic       test_pattern;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gpio_video_tx #(
    .PIX_DIV (1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
`ifdef GPIO_TX_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .tx_data     (tx_data),
    .tx_hsync_n  (tx_hsync_n),
    .tx_vsync_n  (tx_vsync_n),
    .frame_start (frame_start),
    .underflow   (underflow),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_hsync_n"}, 32'(tx_hsync_n), 1);
    check({tag, "_vsync_n"}, 32'(tx_vsync_n), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pix_ready"}, 32'(pix_ready), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  int         p, hp, rp;
  logic       in_frame, e_act, e_hs, e_vs, e_fs, e_busy, e_uf, e_rdy;
  logic [2:0] e_data;
  logic       prev_hs;
  int         hs_falls, first_fall, second_fall, hs_low_l0, hs_falls_in_vs;
  int         vs_low, first_vs, fs_cnt, rdy_total, line_rdy, bad_lines;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
`ifdef GPIO_TX_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    step();
    step();
    check_idle("reset");
    check("reset_underflow", 32'(underflow), 0);
    reset_n = 1'b1;
    step();
    step();
    check_idle("idle_disabled");

    // One full frame; pixel value = col[2:0], one dropped pixel, enable dropped at row 100
    prev_hs = 1'b1;
    hs_falls = 0; first_fall = -1; second_fall = -1; hs_low_l0 = 0; hs_falls_in_vs = 0;
    vs_low = 0; first_vs = -1; fs_cnt = 0; rdy_total = 0; line_rdy = 0; bad_lines = 0;
    enable = 1'b1;
    pix_valid = 1'b1;
    step();
    for (int c = 0; c <= FRAME + 4; c++) begin
      // Expected outputs show position c-1; pix_ready reflects position c
      p        = c - 1;
      in_frame = (p >= 0) && (p < FRAME);
      hp       = in_frame ? p % LINE : 0;
      rp       = in_frame ? p / LINE : 0;
      e_act    = in_frame && (hp < 256) && (rp < 256);
      e_data   = (e_act && p != DROP) ? 3'(hp % 8) : 3'd0;
      e_hs     = !(in_frame && hp >= 272 && hp < 304);
      e_vs     = !(in_frame && rp >= 260 && rp < 264);
      e_fs     = (p == 0);
      e_busy   = (c >= 1) && (c <= FRAME);
      e_uf     = (c >= DROP + 1);
      e_rdy    = (c < FRAME) && ((c % LINE) < 256) && ((c / LINE) < 256);
      check("frame_cycle",
            {c, tx_data, tx_hsync_n, tx_vsync_n, frame_start, busy, underflow, pix_ready},
            {c, e_data, e_hs, e_vs, e_fs, e_busy, e_uf, e_rdy});

      if (prev_hs && !tx_hsync_n) begin
        hs_falls++;
        if (hs_falls == 1) first_fall = c;
        if (hs_falls == 2) second_fall = c;
        if (!tx_vsync_n) hs_falls_in_vs++;
      end
      prev_hs = tx_hsync_n;
      if (!tx_hsync_n && c <= LINE) hs_low_l0++;
      if (!tx_vsync_n) begin
        vs_low++;
        if (first_vs < 0) first_vs = c;
      end
      if (frame_start) fs_cnt++;
      if (pix_ready) begin
        rdy_total++;
        line_rdy++;
      end
      if ((c % LINE) == LINE - 1) begin
        if ((c / LINE) < 256 && line_rdy != 256) bad_lines++;
        line_rdy = 0;
      end

      pix_data  = 3'((c % LINE) % 8);
      pix_valid = (c != DROP);
      if (c == STOP) enable = 1'b0;
      step();
    end
    check("ready_lines_not_256", bad_lines, 0);
    check("ready_total", rdy_total, 256 * 256);
    check("hsync_first_fall", first_fall, 273);
    check("hsync_period", second_fall - first_fall, LINE);
    check("hsync_width_line0", hs_low_l0, 32);
    check("vsync_low_ticks", vs_low, 4 * LINE);
    check("vsync_first_low", first_vs, 260 * LINE + 1);
    check("hsync_pulses_in_vsync", hs_falls_in_vs, 4);
    check("frame_start_count", fs_cnt, 1);
    check_idle("after_stop");
    check("underflow_sticky", 32'(underflow), 1);

    // Reset in the middle of a frame at row 10, col 100
    enable    = 1'b1;
    pix_valid = 1'b1;
    step();
    for (int c = 0; c < 10 * LINE + 100; c++) begin
      pix_data = 3'((c % LINE) % 8);
      step();
    end
    check("mid_busy", 32'(busy), 1);
    check("mid_tx_data", 32'(tx_data), 3);  // pixel 99 of row 10
    check("mid_pix_ready", 32'(pix_ready), 1);
    reset_n = 1'b0;
    step();
    check_idle("mid_reset");
    check("mid_reset_underflow", 32'(underflow), 0);
    enable  = 1'b0;
    reset_n = 1'b1;
    step();
    step();
    check_idle("post_reset");

`ifdef GPIO_TX_TEST_PATTERN_EN
    // Colour bars with no upstream data: no ready, no underflow
    test_pattern = 1'b1;
    pix_valid    = 1'b0;
    enable       = 1'b1;
    step();
    for (int c = 0; c <= LINE; c++) begin
      check("tp_pix_ready", 32'(pix_ready), 0);
      if (c == 1 || c == 32) check("tp_bar0", 32'(tx_data), 0);
      if (c == 129) check("tp_bar4", 32'(tx_data), 4);
      if (c == 225 || c == 256) check("tp_bar7", 32'(tx_data), 7);
      step();
    end
    check("tp_underflow", 32'(underflow), 0);
    enable = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
